hanoi_solver: RTL and testbench

HANOI_SOLVER -- requirements
Module: hanoi_solver

---
 rtl/hanoi_solver.sv | 189 ++++++++++++++++++
 tb/tb_hanoi_solver.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hanoi_solver.sv
// hanoi_solver: Towers of Hanoi move generator.
//   Produces the optimal move sequence for N_DISKS disks from peg 0 to peg 2,
//   one move per advance trigger (timed in auto mode, step edge otherwise),
//   and presents each move on a valid/ready handshake while tracking peg
//   occupancy.
// Parameters:
//   N_DISKS  - number of disks, 1..7
//   RATE_DIV - msclk cycles between moves in auto mode, >= 2
// Ports:
//   msclk      in   clock
//   rst_n      in   asynchronous active-low reset
//   start      in   pulse: reload tower on peg 0 and begin a solve
//   auto       in   1 = timed advance, 0 = step advance
//   step       in   rising edge requests one move in step mode
//   pause      in   freezes the auto timer
//   move_ready in   consumer accepts the presented move
//   move_valid out  move_disk/move_from/move_to are valid
//   move_disk  out  disk number, 1 = smallest
//   move_from  out  source peg
//   move_to    out  destination peg
//   move_count out  moves accepted so far
//   peg0..peg2 out  occupancy bitmaps, bit i = disk i+1
//   busy       out  solve in progress
//   done       out  solve complete
module hanoi_solver #(
    parameter int N_DISKS  = 4,
    parameter int RATE_DIV = 1000
) (
    input  logic               msclk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               auto,
    input  logic               step,
    input  logic               pause,
    input  logic               move_ready,
    output logic               move_valid,
    output logic [2:0]         move_disk,
    output logic [1:0]         move_from,
    output logic [1:0]         move_to,
    output logic [N_DISKS-1:0] move_count,
    output logic [N_DISKS-1:0] peg0,
    output logic [N_DISKS-1:0] peg1,
    output logic [N_DISKS-1:0] peg2,
    output logic               busy,
    output logic               done
);

    localparam int                 TIMER_W    = $clog2(RATE_DIV);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RATE_DIV - 1);
    localparam logic [N_DISKS-1:0] FULL       = '1;
    // The last move number (2^N - 1) is the all-ones count value.
    localparam logic [N_DISKS-1:0] LAST_MOVE  = '1;
    localparam bit                 SWAP_PEGS  = (N_DISKS % 2) == 0;

    typedef enum logic [2:0] {IDLE, WAIT, CALC, PRESENT, DONE} state_t;

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               step_prev;
    logic               trigger;
    logic [8:0]         k;
    logic [8:0]         k_low;
    logic [8:0]         k_fill;
    logic [2:0]         calc_disk;
    logic [1:0]         calc_from;
    logic [1:0]         calc_to;
    logic [N_DISKS-1:0] disk_mask;
    logic [N_DISKS-1:0] next_count;

    // Reduce a value mod 3 to a peg index. For an even disk count the
    // natural sequence ends on peg 1, so pegs 1 and 2 are exchanged.
    function automatic logic [1:0] map_peg(input logic [8:0] v);
        logic [1:0] p;
        p = 2'(v % 9'd3);
        if (SWAP_PEGS && p != 2'd0)
            p = 2'd3 - p;
        return p;
    endfunction

    // New bitmap for peg idx after moving the disk selected by mask.
    function automatic logic [N_DISKS-1:0] apply_move(
        input logic [N_DISKS-1:0] peg,
        input logic [1:0]         idx,
        input logic [1:0]         from,
        input logic [1:0]         to,
        input logic [N_DISKS-1:0] mask
    );
        logic [N_DISKS-1:0] r;
        r = peg;
        if (from == idx)
            r = r & ~mask;
        if (to == idx)
            r = r | mask;
        return r;
    endfunction

    // Move k (1-based) of the optimal solution in closed form: the disk is
    // one plus the trailing-zero count of k; the pegs come from the binary
    // structure of k and k-1.
    always_comb begin
        k         = 9'(move_count) + 9'd1;
        k_low     = k & (k - 9'd1);
        k_fill    = (k | (k - 9'd1)) + 9'd1;
        calc_disk = 3'd1;
        for (int i = 6; i >= 0; i--) begin
            if (k[i])
                calc_disk = 3'(i + 1);
        end
        calc_from  = map_peg(k_low);
        calc_to    = map_peg(k_fill);
        disk_mask  = N_DISKS'(1) << (move_disk - 3'd1);
        next_count = move_count + N_DISKS'(1);
        // Pause freezes the auto trigger as well as the count, so a pause
        // of n cycles delays the move by exactly n cycles.
        trigger    = auto ? (!pause && timer == TIMER_LAST) : (step && !step_prev);
    end

    always_ff @(posedge msclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            move_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_disk  <= 3'd0;
            move_from  <= 2'd0;
            move_to    <= 2'd0;
            move_count <= '0;
            timer      <= '0;
            step_prev  <= 1'b0;
            peg0       <= FULL;
            peg1       <= '0;
            peg2       <= '0;
        end else begin
            // Tracked in every state so edges outside WAIT are consumed.
            step_prev <= step;
            if (start) begin
                state      <= WAIT;
                move_valid <= 1'b0;
                busy       <= 1'b1;
                done       <= 1'b0;
                move_disk  <= 3'd0;
                move_from  <= 2'd0;
                move_to    <= 2'd0;
                move_count <= '0;
                timer      <= '0;
                peg0       <= FULL;
                peg1       <= '0;
                peg2       <= '0;
            end else begin
                case (state)
                    WAIT: begin
                        // The timer runs in either mode and saturates, so
                        // switching mode never restarts it.
                        if (trigger)
                            state <= CALC;
                        else if (!pause && timer != TIMER_LAST)
                            timer <= timer + TIMER_W'(1);
                    end
                    CALC: begin
                        move_disk  <= calc_disk;
                        move_from  <= calc_from;
                        move_to    <= calc_to;
                        move_valid <= 1'b1;
                        state      <= PRESENT;
                    end
                    PRESENT: begin
                        if (move_ready) begin
                            peg0       <= apply_move(peg0, 2'd0, move_from, move_to, disk_mask);
                            peg1       <= apply_move(peg1, 2'd1, move_from, move_to, disk_mask);
                            peg2       <= apply_move(peg2, 2'd2, move_from, move_to, disk_mask);
                            move_count <= next_count;
                            move_valid <= 1'b0;
                            if (next_count == LAST_MOVE) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= WAIT;
                                timer <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hanoi_solver.sv
// Testbench for hanoi_solver: a randomized and directed run on an N=4
// instance checked every cycle against a recursive Hanoi model, plus
// directed runs on N=3 and N=1 instances with literal expectations.
module tb_hanoi_solver;

    localparam int NA    = 4;
    localparam int RA    = 4;
    localparam int FULLA = (1 << NA) - 1;

    logic msclk = 1'b0;
    always #5 msclk = ~msclk;

    logic rst_n;

    logic       start_a, auto_a, step_a, pause_a, ready_a;
    logic       valid_a, busy_a, done_a;
    logic [2:0] disk_a;
    logic [1:0] from_a, to_a;
    logic [3:0] count_a, p0_a, p1_a, p2_a;

    logic       start_b, auto_b, step_b, pause_b, ready_b;
    logic       valid_b, busy_b, done_b;
    logic [2:0] disk_b;
    logic [1:0] from_b, to_b;
    logic [2:0] count_b, p0_b, p1_b, p2_b;

    logic       start_c, auto_c, step_c, pause_c, ready_c;
    logic       valid_c, busy_c, done_c;
    logic [2:0] disk_c;
    logic [1:0] from_c, to_c;
    logic [0:0] count_c, p0_c, p1_c, p2_c;

    hanoi_solver #(.N_DISKS(NA), .RATE_DIV(RA)) dut_a (
        .msclk(msclk), .rst_n(rst_n), .start(start_a), .auto(auto_a),
        .step(step_a), .pause(pause_a), .move_ready(ready_a),
        .move_valid(valid_a), .move_disk(disk_a), .move_from(from_a),
        .move_to(to_a), .move_count(count_a), .peg0(p0_a), .peg1(p1_a),
        .peg2(p2_a), .busy(busy_a), .done(done_a)
    );

    hanoi_solver #(.N_DISKS(3), .RATE_DIV(4)) dut_b (
        .msclk(msclk), .rst_n(rst_n), .start(start_b), .auto(auto_b),
        .step(step_b), .pause(pause_b), .move_ready(ready_b),
        .move_valid(valid_b), .move_disk(disk_b), .move_from(from_b),
        .move_to(to_b), .move_count(count_b), .peg0(p0_b), .peg1(p1_b),
        .peg2(p2_b), .busy(busy_b), .done(done_b)
    );

    hanoi_solver #(.N_DISKS(1), .RATE_DIV(2)) dut_c (
        .msclk(msclk), .rst_n(rst_n), .start(start_c), .auto(auto_c),
        .step(step_c), .pause(pause_c), .move_ready(ready_c),
        .move_valid(valid_c), .move_disk(disk_c), .move_from(from_c),
        .move_to(to_c), .move_count(count_c), .peg0(p0_c), .peg1(p1_c),
        .peg2(p2_c), .busy(busy_c), .done(done_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference move list from the textbook recursive solution.
    int ed[$];
    int ef[$];
    int et[$];

    function automatic void gen(input int n, input int s, input int d, input int a);
        if (n == 0)
            return;
        gen(n - 1, s, a, d);
        ed.push_back(n);
        ef.push_back(s);
        et.push_back(d);
        gen(n - 1, a, d, s);
    endfunction

    // Model for instance A. Phase: 0 idle, 1 waiting, 2 computing,
    // 3 presenting, 4 finished. m_u counts unpaused waiting cycles.
    int   m_peg[3];
    int   m_cnt;
    int   m_phase;
    int   m_u;
    logic m_sprev;

    always @(negedge msclk) begin
        if (!rst_n) begin
            chk("rst_valid", valid_a, 0);
            chk("rst_busy", busy_a, 0);
            chk("rst_done", done_a, 0);
            chk("rst_count", count_a, 0);
            chk("rst_disk", disk_a, 0);
            chk("rst_from", from_a, 0);
            chk("rst_to", to_a, 0);
            chk("rst_peg0", p0_a, FULLA);
            chk("rst_peg1", p1_a, 0);
            chk("rst_peg2", p2_a, 0);
            m_peg   = '{FULLA, 0, 0};
            m_cnt   = 0;
            m_phase = 0;
            m_u     = 0;
            m_sprev = 1'b0;
        end else begin
            chk("count", count_a, m_cnt);
            chk("peg0", p0_a, m_peg[0]);
            chk("peg1", p1_a, m_peg[1]);
            chk("peg2", p2_a, m_peg[2]);
            chk("valid", valid_a, (m_phase == 3) ? 1 : 0);
            chk("busy", busy_a, (m_phase >= 1 && m_phase <= 3) ? 1 : 0);
            chk("done", done_a, (m_phase == 4) ? 1 : 0);
            if (valid_a && m_phase == 3 && m_cnt < FULLA) begin
                chk("move_disk", disk_a, ed[m_cnt]);
                chk("move_from", from_a, ef[m_cnt]);
                chk("move_to", to_a, et[m_cnt]);
                chk("from_ne_to", (from_a != to_a) ? 1 : 0, 1);
                if (from_a < 2'd3 && to_a < 2'd3 && disk_a >= 3'd1) begin
                    chk("src_top", m_peg[from_a] & ((1 << disk_a) - 1), 1 << (disk_a - 1));
                    chk("dst_clear", m_peg[to_a] & ((1 << disk_a) - 1), 0);
                end
            end
            if (start_a) begin
                m_peg   = '{FULLA, 0, 0};
                m_cnt   = 0;
                m_phase = 1;
                m_u     = 0;
            end else begin
                case (m_phase)
                    1: begin
                        if (auto_a ? (!pause_a && m_u == RA - 1) : (step_a && !m_sprev))
                            m_phase = 2;
                        else if (!pause_a && m_u < RA - 1)
                            m_u++;
                    end
                    2: m_phase = 3;
                    3: begin
                        if (ready_a) begin
                            m_peg[ef[m_cnt]] &= ~(1 << (ed[m_cnt] - 1));
                            m_peg[et[m_cnt]] |= (1 << (ed[m_cnt] - 1));
                            m_cnt++;
                            m_phase = (m_cnt == FULLA) ? 4 : 1;
                            m_u     = 0;
                        end
                    end
                    default: ;
                endcase
            end
            m_sprev = step_a;
        end
    end

    function automatic logic cur_valid(input int which);
        case (which)
            0:       return valid_a;
            1:       return valid_b;
            default: return valid_c;
        endcase
    endfunction

    // Returns the number of rising edges until move_valid is seen high.
    task automatic wait_valid(input int which, output int n);
        n = 0;
        while (n < 300) begin
            @(posedge msclk);
            #1;
            n++;
            if (cur_valid(which))
                return;
        end
        checks++;
        errors++;
        $display("FAIL wait_valid[%0d]: no move_valid within %0d cycles", which, n);
    endtask

    task automatic wait_done_a(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge msclk);
            #1;
            if (done_a)
                return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: done not seen within %0d cycles", limit);
    endtask

    task automatic pulse_start(input int which);
        case (which)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge msclk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic step_b_pulse();
        step_b = 1'b1;
        @(posedge msclk);
        #1;
        step_b = 1'b0;
    endtask

    initial begin
        int n;
        int sd, sf, st;
        int bd[7];
        int bf[7];
        int bt[7];
        bd = '{1, 2, 1, 3, 1, 2, 1};
        bf = '{0, 0, 2, 0, 1, 1, 0};
        bt = '{2, 1, 1, 2, 0, 2, 2};

        rst_n   = 1'b0;
        start_a = 0; auto_a = 0; step_a = 0; pause_a = 0; ready_a = 1;
        start_b = 0; auto_b = 0; step_b = 0; pause_b = 0; ready_b = 1;
        start_c = 0; auto_c = 0; step_c = 0; pause_c = 0; ready_c = 1;

        gen(NA, 0, 2, 1);
        chk("model_len", ed.size(), 15);
        chk("model_first_disk", ed[0], 1);
        chk("model_first_from", ef[0], 0);
        chk("model_first_to", et[0], 1);
        chk("model_mid_disk", ed[7], 4);
        chk("model_mid_to", et[7], 2);

        repeat (3) @(posedge msclk);
        #1 rst_n = 1'b1;

        // Stay idle after reset, even with a step edge.
        step_a = 1'b1;
        @(posedge msclk); #1;
        step_a = 1'b0;
        repeat (3) @(posedge msclk);
        #1;
        chk("idle_busy", busy_a, 0);

        // Auto mode full solve, N=4, RATE_DIV=4.
        auto_a = 1'b1;
        pulse_start(0);
        wait_valid(0, n);
        chk("auto_rise_cycles", n, 5);
        chk("auto_first_disk", disk_a, 1);
        chk("auto_first_from", from_a, 0);
        chk("auto_first_to", to_a, 1);
        wait_done_a(400);
        chk("auto_end_peg2", p2_a, 15);
        chk("auto_end_count", count_a, 15);
        chk("auto_end_done", done_a, 1);

        // Pause for 20 cycles delays the first move by exactly 20.
        pulse_start(0);
        repeat (2) @(posedge msclk);
        #1 pause_a = 1'b1;
        repeat (20) @(posedge msclk);
        #1 pause_a = 1'b0;
        wait_valid(0, n);
        chk("pause_rise_cycles", 22 + n, 25);

        // Backpressure in step mode with extra step edges.
        ready_a = 1'b0;
        auto_a  = 1'b0;
        pulse_start(0);
        step_a = 1'b1;
        @(posedge msclk); #1;
        step_a = 1'b0;
        wait_valid(0, n);
        sd = disk_a; sf = from_a; st = to_a;
        for (int i = 0; i < 10; i++) begin
            step_a = i[0];
            @(posedge msclk); #1;
            chk("bp_valid", valid_a, 1);
            chk("bp_disk", disk_a, sd);
            chk("bp_from", from_a, sf);
            chk("bp_to", to_a, st);
            chk("bp_count", count_a, 0);
        end
        step_a  = 1'b0;
        ready_a = 1'b1;
        @(posedge msclk); #1;
        chk("bp_accept_count", count_a, 1);
        repeat (10) @(posedge msclk);
        #1;
        chk("bp_no_extra_valid", valid_a, 0);
        chk("bp_no_extra_count", count_a, 1);

        // Reset while a move is presented.
        ready_a = 1'b0;
        auto_a  = 1'b1;
        pulse_start(0);
        wait_valid(0, n);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid_a, 0);
        chk("midrst_count", count_a, 0);
        chk("midrst_peg0", p0_a, 15);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        repeat (2) @(posedge msclk);
        #1 rst_n = 1'b1;
        ready_a = 1'b1;
        repeat (6) @(posedge msclk);
        #1;
        chk("post_rst_idle", busy_a, 0);

        // Randomized inputs, model-checked every cycle.
        for (int run = 0; run < 6; run++) begin
            auto_a = 1'($urandom_range(0, 1));
            pulse_start(0);
            for (int c = 0; c < 400; c++) begin
                auto_a  = 1'($urandom_range(0, 1));
                pause_a = ($urandom_range(0, 3) == 0);
                step_a  = 1'($urandom_range(0, 1));
                ready_a = ($urandom_range(0, 2) != 0);
                start_a = ($urandom_range(0, 299) == 0);
                @(posedge msclk); #1;
            end
            start_a = 1'b0;
            auto_a  = 1'b1;
            pause_a = 1'b0;
            step_a  = 1'b0;
            ready_a = 1'b1;
            wait_done_a(600);
            chk("rand_end_peg2", p2_a, 15);
        end

        // N=3, step mode, seven moves.
        pulse_start(1);
        for (int i = 0; i < 7; i++) begin
            step_b_pulse();
            wait_valid(1, n);
            chk("n3_disk", disk_b, bd[i]);
            chk("n3_from", from_b, bf[i]);
            chk("n3_to", to_b, bt[i]);
            @(posedge msclk); #1;
            chk("n3_after_accept_valid", valid_b, 0);
        end
        chk("n3_done", done_b, 1);
        chk("n3_peg2", p2_b, 7);
        chk("n3_count", count_b, 7);
        chk("n3_busy", busy_b, 0);
        step_b_pulse();
        repeat (3) @(posedge msclk);
        #1;
        chk("n3_hold_done", done_b, 1);
        chk("n3_hold_valid", valid_b, 0);
        chk("n3_hold_peg2", p2_b, 7);

        // N=3, start aborting a presented move.
        pulse_start(1);
        for (int i = 0; i < 2; i++) begin
            step_b_pulse();
            wait_valid(1, n);
            @(posedge msclk); #1;
        end
        ready_b = 1'b0;
        step_b_pulse();
        wait_valid(1, n);
        chk("n3_third_disk", disk_b, 1);
        pulse_start(1);
        chk("n3_abort_valid", valid_b, 0);
        chk("n3_abort_count", count_b, 0);
        chk("n3_abort_peg0", p0_b, 7);
        chk("n3_abort_peg1", p1_b, 0);
        chk("n3_abort_peg2", p2_b, 0);
        ready_b = 1'b1;
        step_b_pulse();
        wait_valid(1, n);
        chk("n3_restart_disk", disk_b, 1);
        chk("n3_restart_from", from_b, 0);
        chk("n3_restart_to", to_b, 2);

        // N=1, single move.
        auto_c = 1'b1;
        pulse_start(2);
        wait_valid(2, n);
        chk("n1_rise_cycles", n, 3);
        chk("n1_disk", disk_c, 1);
        chk("n1_from", from_c, 0);
        chk("n1_to", to_c, 2);
        @(posedge msclk); #1;
        chk("n1_done", done_c, 1);
        chk("n1_peg2", p2_c, 1);
        chk("n1_peg0", p0_c, 0);
        chk("n1_count", count_c, 1);
        repeat (4) @(posedge msclk);
        #1;
        chk("n1_hold_valid", valid_c, 0);
        chk("n1_hold_done", done_c, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
